// File: rtl/hub_mult_pkg.sv
// Shared types for the HUB multiplier issue/collect slice: FPU-side operation and status
// types, the operand-width helper and the issuer state encoding.
package hub_mult_pkg;

    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIVSQRT, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic {StRun, StFlush} state_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/hub_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a synchronous clear that wins over push/pop.
module hub_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AddrW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_q[AddrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fpnew_hub_mult_issuer.sv
// Credit-limited issue of multiplications into an FPU slot, with in-order tagged result
// collection, a one-cycle flush state and sticky status flags.
module fpnew_hub_mult_issuer
    import hub_mult_pkg::*;
#(
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned WIDTH    = fp_width(FpFormat),
    parameter int unsigned Depth    = 4,
    parameter int unsigned TagW     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WIDTH-1:0]      req_a_i,
    input  logic [WIDTH-1:0]      req_b_i,
    input  logic [TagW-1:0]       req_tag_i,
    output logic [2:0][WIDTH-1:0] fpu_operands_o,
    output operation_e            fpu_op_o,
    output logic                  fpu_op_mod_o,
    output logic                  fpu_in_valid_o,
    input  logic                  fpu_in_ready_i,
    output logic                  fpu_flush_o,
    input  logic [WIDTH-1:0]      fpu_result_i,
    input  status_t               fpu_status_i,
    input  logic                  fpu_out_valid_i,
    output logic                  fpu_out_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_result_o,
    output status_t               rsp_status_o,
    output logic [TagW-1:0]       rsp_tag_o,
    output status_t               fflags_o,
    input  logic                  fflags_clr_i
);
    localparam int unsigned     CntW     = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        logic [TagW-1:0]  tag;
    } rsp_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] credits_q, credits_d;
    status_t         fflags_q, fflags_d;

    logic            in_run, issue_en, issue_hs, out_hs, accept, rsp_hs, fifo_clr;
    logic            tag_push, tag_pop, tag_full, tag_empty;
    logic [TagW-1:0] tag_head, rsp_tag_sel;
    logic            res_full, res_empty;
    rsp_t            res_in, res_head;

    assign in_run   = (state_q == StRun);
    assign issue_en = in_run && (credits_q < DepthCnt);
    assign fifo_clr = !in_run;

    assign fpu_in_valid_o    = issue_en && req_valid_i;
    assign req_ready_o       = issue_en && fpu_in_ready_i;
    assign issue_hs          = fpu_in_valid_o && fpu_in_ready_i;
    assign fpu_operands_o[0] = '0;
    assign fpu_operands_o[1] = req_a_i;
    assign fpu_operands_o[2] = req_b_i;
    assign fpu_op_o          = MUL;
    assign fpu_op_mod_o      = 1'b0;
    assign fpu_flush_o       = !in_run;
    assign fpu_out_ready_o   = 1'b1;

    // A zero-latency FPU answers in its issue cycle, before the tag has reached the FIFO.
    assign out_hs      = fpu_out_valid_i && fpu_out_ready_o;
    assign accept      = out_hs && in_run && (!tag_empty || issue_hs);
    assign tag_pop     = accept && !tag_empty;
    assign tag_push    = issue_hs && !(accept && tag_empty);
    assign rsp_tag_sel = tag_empty ? req_tag_i : tag_head;

    assign res_in.result = fpu_result_i;
    assign res_in.status = fpu_status_i;
    assign res_in.tag    = rsp_tag_sel;

    assign rsp_valid_o  = in_run && !res_empty;
    assign rsp_hs       = rsp_valid_o && rsp_ready_i;
    assign rsp_result_o = res_head.result;
    assign rsp_status_o = res_head.status;
    assign rsp_tag_o    = res_head.tag;
    assign fflags_o     = fflags_q;

    hub_sync_fifo #(.Width(TagW), .Depth(Depth)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (fifo_clr),
        .push_i  (tag_push),
        .data_i  (req_tag_i),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    hub_sync_fifo #(.Width($bits(rsp_t)), .Depth(Depth)) u_res_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (fifo_clr),
        .push_i  (accept),
        .data_i  (res_in),
        .pop_i   (rsp_hs),
        .data_o  (res_head),
        .full_o  (res_full),
        .empty_o (res_empty)
    );

    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        fflags_d  = fflags_q;
        case (state_q)
            StRun:   state_d = flush_i ? StFlush : StRun;
            StFlush: state_d = flush_i ? StFlush : StRun;
            default: state_d = StRun;
        endcase
        if (!in_run) begin
            credits_d = '0;
        end else if (issue_hs && !rsp_hs) begin
            credits_d = credits_q + 1'b1;
        end else if (!issue_hs && rsp_hs) begin
            credits_d = credits_q - 1'b1;
        end
        if (rsp_hs) begin
            fflags_d = fflags_clr_i ? res_head.status : status_t'(fflags_q | res_head.status);
        end else if (fflags_clr_i) begin
            fflags_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            credits_q <= '0;
            fflags_q  <= '0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            fflags_q  <= fflags_d;
        end
    end

    res_space_a: assert property (@(posedge clk_i) disable iff (!rst_ni) accept |-> !res_full);
    tag_space_a: assert property (@(posedge clk_i) disable iff (!rst_ni) tag_push |-> !tag_full);

endmodule

// File: tb/tb_fpnew_hub_mult_issuer.sv
// Bench for fpnew_hub_mult_issuer: directed vector table, hand-written corner sequences and
// a randomized phase checked against a queue-based model of the issue/response contract.
module tb_fpnew_hub_mult_issuer;
    import hub_mult_pkg::*;

    localparam int Depth = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i, req_valid_i, req_ready_o;
    logic [15:0]      req_a_i, req_b_i;
    logic [3:0]       req_tag_i;
    logic [2:0][15:0] fpu_operands_o;
    operation_e       fpu_op_o;
    logic             fpu_op_mod_o, fpu_in_valid_o, fpu_in_ready_i, fpu_flush_o;
    logic [15:0]      fpu_result_i;
    status_t          fpu_status_i;
    logic             fpu_out_valid_i, fpu_out_ready_o;
    logic             rsp_valid_o, rsp_ready_i;
    logic [15:0]      rsp_result_o;
    status_t          rsp_status_o;
    logic [3:0]       rsp_tag_o;
    status_t          fflags_o;
    logic             fflags_clr_i;

    // Stand-in FPU: zero-latency "product" a+b with status b[4:0], or a manual straggler source.
    logic        fpu_comb, man_valid;
    assign fpu_out_valid_i = fpu_comb ? (fpu_in_valid_o && fpu_in_ready_i) : man_valid;
    assign fpu_result_i    = fpu_comb ? (fpu_operands_o[1] + fpu_operands_o[2]) : 16'hDEAD;
    assign fpu_status_i    = fpu_comb ? status_t'(fpu_operands_o[2][4:0]) : status_t'(5'h1F);

    always #5 clk_i = ~clk_i;

    fpnew_hub_mult_issuer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .req_tag_i       (req_tag_i),
        .fpu_operands_o  (fpu_operands_o),
        .fpu_op_o        (fpu_op_o),
        .fpu_op_mod_o    (fpu_op_mod_o),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (fpu_in_ready_i),
        .fpu_flush_o     (fpu_flush_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_status_o    (rsp_status_o),
        .rsp_tag_o       (rsp_tag_o),
        .fflags_o        (fflags_o),
        .fflags_clr_i    (fflags_clr_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b1;
            req_a_i     = a;
            req_b_i     = b;
            req_tag_i   = tag;
            #1;
            if (req_ready_o) begin
                @(posedge clk_i);
                done = 1;
                break;
            end
        end
        #1 req_valid_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: tag %0d not accepted within 20 cycles", tag);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] exp_res;
        logic [4:0]  exp_st;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  st;
        logic [3:0]  tag;
    } exp_t;

    vec_t       vecs [4];
    exp_t       exp_q [$];
    logic [3:0] got [$];
    logic [4:0] flags_m;
    int         nacc, nxt;
    bit         acc, popv, exp_ready;
    logic [3:0] t;

    initial begin
        vecs[0] = '{a: 16'h3C00, b: 16'h4000, tag: 4'd3,  exp_res: 16'h7C00, exp_st: 5'h00};
        vecs[1] = '{a: 16'h0001, b: 16'h0002, tag: 4'd5,  exp_res: 16'h0003, exp_st: 5'h02};
        vecs[2] = '{a: 16'hFFFF, b: 16'h0001, tag: 4'd15, exp_res: 16'h0000, exp_st: 5'h01};
        vecs[3] = '{a: 16'h1234, b: 16'h1111, tag: 4'd0,  exp_res: 16'h2345, exp_st: 5'h11};

        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_a_i = '0; req_b_i = '0;
        req_tag_i = '0; fpu_in_ready_i = 1'b0; rsp_ready_i = 1'b0; fflags_clr_i = 1'b0;
        fpu_comb = 1'b1; man_valid = 1'b0;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_in_valid", 32'(fpu_in_valid_o), 0);
        chk("rst_req_ready", 32'(req_ready_o), 0);
        chk("rst_flush", 32'(fpu_flush_o), 0);
        chk("rst_out_ready", 32'(fpu_out_ready_o), 1);
        chk("rst_fflags", 32'(fflags_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        fpu_in_ready_i = 1'b1;

        // Directed single operations
        foreach (vecs[i]) begin
            @(negedge clk_i);
            req_valid_i = 1'b1; req_a_i = vecs[i].a; req_b_i = vecs[i].b;
            req_tag_i = vecs[i].tag; rsp_ready_i = 1'b0;
            #1;
            chk("vec_op0", 32'(fpu_operands_o[0]), 0);
            chk("vec_op1", 32'(fpu_operands_o[1]), 32'(vecs[i].a));
            chk("vec_op2", 32'(fpu_operands_o[2]), 32'(vecs[i].b));
            chk("vec_op", 32'(fpu_op_o), 32'(MUL));
            chk("vec_op_mod", 32'(fpu_op_mod_o), 0);
            chk("vec_in_valid", 32'(fpu_in_valid_o), 1);
            chk("vec_req_ready", 32'(req_ready_o), 1);
            chk("vec_rsp_not_yet", 32'(rsp_valid_o), 0);
            @(negedge clk_i);
            req_valid_i = 1'b0; rsp_ready_i = 1'b1;
            #1;
            chk("vec_rsp_valid", 32'(rsp_valid_o), 1);
            chk("vec_rsp_result", 32'(rsp_result_o), 32'(vecs[i].exp_res));
            chk("vec_rsp_status", 32'(rsp_status_o), 32'(vecs[i].exp_st));
            chk("vec_rsp_tag", 32'(rsp_tag_o), 32'(vecs[i].tag));
            @(negedge clk_i);
            #1;
            chk("vec_rsp_drained", 32'(rsp_valid_o), 0);
        end

        // Back-pressure: 6 requests against a blocked response port
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            req_valid_i = 1'b1; req_tag_i = 4'(nacc); req_a_i = 16'(c); req_b_i = 16'h0;
            #1;
            acc = req_ready_o;
            @(posedge clk_i);
            if (acc) nacc++;
        end
        #1;
        chk("bp_accepted", 32'(nacc), 4);
        chk("bp_ready_low", 32'(req_ready_o), 0);
        got.delete();
        nxt = nacc;
        for (int c = 0; c < 30 && got.size() < 6; c++) begin
            @(negedge clk_i);
            rsp_ready_i = 1'b1;
            req_valid_i = (nxt < 6);
            req_tag_i   = 4'(nxt);
            #1;
            if (c == 0) chk("bp_no_same_cycle_reissue", 32'(req_ready_o), 0);
            acc  = req_valid_i && req_ready_o;
            popv = rsp_valid_o;
            t    = rsp_tag_o;
            @(posedge clk_i);
            if (acc) nxt++;
            if (popv) got.push_back(t);
        end
        #1 req_valid_i = 1'b0;
        chk("bp_rsp_count", 32'(got.size()), 6);
        foreach (got[i]) chk("bp_tag_order", 32'(got[i]), 32'(i));

        // FPU stall: request held while in_ready is low
        @(negedge clk_i);
        req_valid_i = 1'b1; req_a_i = 16'h1111; req_b_i = 16'h2222; req_tag_i = 4'd7;
        fpu_in_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_req_ready", 32'(req_ready_o), 0);
            chk("stall_in_valid", 32'(fpu_in_valid_o), 1);
            chk("stall_op1", 32'(fpu_operands_o[1]), 32'h1111);
            chk("stall_op2", 32'(fpu_operands_o[2]), 32'h2222);
            chk("stall_credits", 32'(dut.credits_q), 0);
            @(negedge clk_i);
        end
        fpu_in_ready_i = 1'b1;
        #1;
        chk("stall_release_ready", 32'(req_ready_o), 1);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("stall_rsp_tag", 32'(rsp_tag_o), 7);
        chk("stall_rsp_result", 32'(rsp_result_o), 32'h3333);
        idle_cycles(2);

        // Flush with three buffered results and straggler FPU outputs
        rsp_ready_i = 1'b0;
        issue_one(16'h0100, 16'h0000, 4'd1);
        issue_one(16'h0200, 16'h0000, 4'd2);
        issue_one(16'h0300, 16'h0000, 4'd3);
        @(negedge clk_i);
        #1;
        chk("flush_pre_credits", 32'(dut.credits_q), 3);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; fpu_comb = 1'b0; man_valid = 1'b1;
        #1;
        chk("flush_fpu_flush", 32'(fpu_flush_o), 1);
        chk("flush_rsp_valid", 32'(rsp_valid_o), 0);
        chk("flush_req_ready", 32'(req_ready_o), 0);
        chk("flush_out_ready", 32'(fpu_out_ready_o), 1);
        @(negedge clk_i);
        #1;
        chk("flush_one_cycle", 32'(fpu_flush_o), 0);
        chk("flush_credits", 32'(dut.credits_q), 0);
        chk("flush_rsp_cleared", 32'(rsp_valid_o), 0);
        @(negedge clk_i);
        man_valid = 1'b0; fpu_comb = 1'b1;
        #1;
        chk("straggler_discarded", 32'(rsp_valid_o), 0);
        issue_one(16'h0042, 16'h0000, 4'd9);
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        #1;
        chk("post_flush_valid", 32'(rsp_valid_o), 1);
        chk("post_flush_tag", 32'(rsp_tag_o), 9);
        chk("post_flush_result", 32'(rsp_result_o), 32'h0042);
        idle_cycles(2);

        // Sticky flags, then clear concurrent with a delivery
        @(negedge clk_i);
        fflags_clr_i = 1'b1;
        @(negedge clk_i);
        fflags_clr_i = 1'b0;
        #1;
        chk("flags_cleared", 32'(fflags_o), 0);
        issue_one(16'h0000, 16'h0004, 4'd1);
        issue_one(16'h0000, 16'h0002, 4'd2);
        idle_cycles(2);
        chk("flags_of_uf", 32'(fflags_o), 32'h06);
        rsp_ready_i = 1'b0;
        issue_one(16'h0000, 16'h0001, 4'd3);
        @(negedge clk_i);
        rsp_ready_i = 1'b1; fflags_clr_i = 1'b1;
        #1;
        chk("flags_nx_valid", 32'(rsp_valid_o), 1);
        @(posedge clk_i);
        #1 fflags_clr_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("flags_set_wins", 32'(fflags_o), 32'h01);

        // Asynchronous reset with two results buffered
        rsp_ready_i = 1'b0;
        issue_one(16'h0005, 16'h0004, 4'd4);
        issue_one(16'h0006, 16'h0004, 4'd5);
        @(negedge clk_i);
        #1;
        chk("areset_pre_valid", 32'(rsp_valid_o), 1);
        #2 rst_ni = 1'b0; fpu_in_ready_i = 1'b0;
        #1;
        chk("areset_rsp_valid", 32'(rsp_valid_o), 0);
        chk("areset_fflags", 32'(fflags_o), 0);
        chk("areset_flush", 32'(fpu_flush_o), 0);
        chk("areset_req_ready", 32'(req_ready_o), 0);
        chk("areset_in_valid", 32'(fpu_in_valid_o), 0);
        chk("areset_out_ready", 32'(fpu_out_ready_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b1; rsp_ready_i = 1'b1; fpu_in_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            #1;
            chk("areset_no_rsp", 32'(rsp_valid_o), 0);
        end

        // Randomized traffic against the queue model
        exp_q.delete();
        flags_m = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            req_valid_i    = 1'($urandom_range(0, 1));
            req_a_i        = 16'($urandom);
            req_b_i        = 16'($urandom);
            req_tag_i      = 4'($urandom);
            fpu_in_ready_i = ($urandom_range(0, 3) != 0);
            rsp_ready_i    = ($urandom_range(0, 2) != 0);
            fflags_clr_i   = ($urandom_range(0, 15) == 0);
            #1;
            exp_ready = fpu_in_ready_i && (exp_q.size() < Depth);
            chk("rnd_req_ready", 32'(req_ready_o), 32'(exp_ready));
            chk("rnd_in_valid", 32'(fpu_in_valid_o),
                32'(req_valid_i && (exp_q.size() < Depth)));
            chk("rnd_rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() != 0));
            chk("rnd_fflags", 32'(fflags_o), 32'(flags_m));
            if (exp_q.size() != 0) begin
                chk("rnd_rsp_tag", 32'(rsp_tag_o), 32'(exp_q[0].tag));
                chk("rnd_rsp_result", 32'(rsp_result_o), 32'(exp_q[0].res));
                chk("rnd_rsp_status", 32'(rsp_status_o), 32'(exp_q[0].st));
            end
            @(posedge clk_i);
            if (exp_q.size() != 0 && rsp_ready_i) begin
                flags_m = fflags_clr_i ? exp_q[0].st : (flags_m | exp_q[0].st);
                void'(exp_q.pop_front());
            end else if (fflags_clr_i) begin
                flags_m = '0;
            end
            if (exp_ready && req_valid_i) begin
                exp_q.push_back('{res: req_a_i + req_b_i, st: req_b_i[4:0], tag: req_tag_i});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
